// File: rtl/verin_sample_logger.sv
// Avalon-MM initiator that logs verin samples into on-chip RAM as a circular buffer and serves
// single-word readbacks. Define VERIN_LOGGER_SEQ_EN to stamp an 8-bit sequence into bits 31:24.
module verin_sample_logger #(
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned DEPTH        = 5000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_index,
  output logic              rd_ready,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  input  logic              clear,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] count,
  output logic              overflow,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LP_FULL  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W:0]   LP_LIMIT = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]        LP_LAT   = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StReadWait} state_e;

  state_e            r_state;
  state_e            w_next_state;
  logic              r_idle_rdy;
  logic [31:0]       r_sample;
  logic [ADDR_W-1:0] r_index;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_count;
  logic              r_overflow;
  logic [31:0]       r_rd_data;
  logic              r_rd_valid;
  logic              r_rd_err;
  logic [1:0]        r_lat_cnt;
  logic [31:0]       w_wdata;
`ifdef VERIN_LOGGER_SEQ_EN
  logic [7:0]        r_seq;
`endif

  logic w_clear_go;
  logic w_sample_go;
  logic w_rd_go;
  logic w_rd_oob;
  logic w_wr_done;
  logic w_rd_acc;

  // Readies come from a registered idle flag; the clear/valid gating keeps the IDLE priority
  // consistent with the valid&ready handshake.
  assign sample_ready = r_idle_rdy & ~clear;
  assign rd_ready     = r_idle_rdy & ~clear & ~sample_valid;

  assign w_clear_go  = (r_state == StIdle) & clear;
  assign w_sample_go = sample_valid & sample_ready;
  assign w_rd_go     = rd_req & rd_ready;
  assign w_rd_oob    = {1'b0, rd_index} >= LP_LIMIT;
  assign w_wr_done   = (r_state == StWrite) & ~avm_waitrequest;
  assign w_rd_acc    = (r_state == StRead) & ~avm_waitrequest;

`ifdef VERIN_LOGGER_SEQ_EN
  assign w_wdata = {r_seq, r_sample[23:0]};
`else
  assign w_wdata = r_sample;
`endif

  assign wr_ptr   = r_wr_ptr;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_idle_rdy <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_idle_rdy <= (w_next_state == StIdle);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      StIdle: begin
        if (w_sample_go) begin
          w_next_state = StWrite;
        end else if (w_rd_go && !w_rd_oob) begin
          w_next_state = StRead;
        end
      end
      StWrite:    if (!avm_waitrequest) w_next_state = StIdle;
      StRead:     if (!avm_waitrequest) w_next_state = StReadWait;
      StReadWait: if (r_lat_cnt == 2'd0) w_next_state = StIdle;
      default:    w_next_state = StIdle;
    endcase
  end

  always_comb begin
    avm_chipselect = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_writedata  = '0;
    case (r_state)
      StWrite: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = r_wr_ptr;
        avm_writedata  = w_wdata;
      end
      StRead: begin
        avm_chipselect = 1'b1;
        avm_address    = r_index;
      end
      default: ;
    endcase
    avm_byteenable = avm_chipselect ? 4'hF : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sample   <= '0;
      r_index    <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_lat_cnt  <= '0;
`ifdef VERIN_LOGGER_SEQ_EN
      r_seq      <= '0;
`endif
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      if (w_clear_go) begin
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
`ifdef VERIN_LOGGER_SEQ_EN
        r_seq      <= '0;
`endif
      end
      if (w_sample_go) r_sample <= sample_data;
      if (w_rd_go) begin
        if (w_rd_oob) r_rd_err <= 1'b1;
        else          r_index  <= rd_index;
      end
      if (w_wr_done) begin
        r_wr_ptr <= (r_wr_ptr == LP_LAST) ? '0 : r_wr_ptr + 1'b1;
        // A full log keeps its count; the oldest entry is being overwritten.
        if (r_count == LP_FULL) r_overflow <= 1'b1;
        else                    r_count    <= r_count + 1'b1;
`ifdef VERIN_LOGGER_SEQ_EN
        r_seq <= r_seq + 8'd1;
`endif
      end
      if (w_rd_acc) begin
        r_lat_cnt <= LP_LAT;
      end else if (r_state == StReadWait) begin
        if (r_lat_cnt == 2'd0) begin
          r_rd_data  <= avm_readdata;
          r_rd_valid <= 1'b1;
        end else begin
          r_lat_cnt <= r_lat_cnt - 2'd1;
        end
      end
    end
  end

endmodule
